loop_nest_counter: RTL and testbench
====================================

// Module: loop_nest_counter
//
// PURPOSE
//  Parametrised nested-loop index generator for the blocked matmul datapath.
//  Chains NUM_DIMS wrap-around counters (dim 0 innermost) with per-dim runtime bounds.
//  Emits one index tuple per valid/ready handshake and pulses done after the final tuple.
//  Sits between the tile controller (start/bounds) and the address generators (idx consumers).
//
// PARAMETERS
//  NUM_DIMS   3  number of nested loop dimensions (>=1)
//  MAX_COUNT  8  largest supported per-dim bound (>=1); CW = $clog2(MAX_COUNT+1)
//
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              asynchronous, active-low reset
//  start      in   1              begin a loop nest; sampled only in IDLE
//  clear      in   1              synchronous abort to IDLE; wins over start
//  bounds     in   NUM_DIMS*CW    per-dim trip counts, dim d at [d*CW +: CW]; sampled with start
//  idx_valid  out  1              idx/idx_last hold a valid tuple
//  idx_ready  in   1              consumer accepts tuple when idx_valid & idx_ready
//  idx        out  NUM_DIMS*CW    current indices, dim d at [d*CW +: CW], range 0..bound_d-1
//  idx_last   out  NUM_DIMS       bit d = 1 when idx_d == bound_d-1
//  busy       out  1              1 in RUN
//  done       out  1              one-cycle pulse in DONE
//
// BEHAVIOUR
//  - Reset (rst low, async): state=IDLE; idx=0, stored bounds=0, idx_valid=0, busy=0, done=0.
//  - States: IDLE -> RUN on start & ~clear; RUN -> DONE on final handshake; DONE -> IDLE always.
//    Any state -> IDLE on clear (idx_valid=0, busy=0, no done pulse).
//  - Bounds load: on accepted start, each bound_d is registered with clamping:
//    0 -> 1, >MAX_COUNT -> MAX_COUNT. Later changes to bounds have no effect until next start.
//  - Latency: start accepted in cycle N -> idx_valid=1, idx all zero, busy=1 in cycle N+1.
//  - start in RUN or DONE is ignored (no restart, no bound reload).
//  - Handshake: on idx_valid & idx_ready, advance. While idx_valid & ~idx_ready,
//    idx and idx_last hold stable; idx_valid never drops in RUN without a handshake.
//  - Advance rule: dim 0 increments each handshake; dim d>0 increments only when
//    idx_last[d-1:0] all 1. A dim at its last value that increments wraps to 0.
//  - Final tuple: idx_last all 1. Its handshake moves to DONE: idx_valid=0, busy=0,
//    done=1 that cycle, idx returns to 0. Next cycle IDLE, done=0; new start then accepted.
//  - idx_last is decoded from registered idx and stored bounds (no comb path from inputs).
//  - Total tuples per nest = product of clamped bounds; order is row-major, dim 0 fastest.
//  - clear and final handshake in same cycle: clear wins, no done pulse.
//  - Counter arithmetic is CW bits; bound MAX_COUNT never overflows CW.
//
// TESTING
//  1. NUM_DIMS=3, bounds {d2=2,d1=3,d0=2}, ready=1 -> 12 tuples (0,0,0),(0,0,1),(0,1,0)..(1,2,1)
//     on consecutive cycles, then done=1 for exactly one cycle, busy=0.
//  2. Same bounds, idx_ready toggled 1/0 pseudo-randomly -> same 12 tuples in order;
//     idx stable whenever valid & ~ready; no tuple duplicated or skipped.
//  3. bounds {0,9,1} with MAX_COUNT=8 -> clamped {1,8,1}: 8 tuples, d1 counts 0..7;
//     idx_last[0] and idx_last[2] constantly 1.
//  4. clear asserted after 5th handshake of test 1 -> next cycle idx_valid=0, busy=0,
//     done never pulses; fresh start then restarts from (0,0,0).
//  5. rst pulsed low mid-run (between clock edges) -> outputs 0 immediately;
//     start pulse in RUN (no reset) -> ignored, sequence unaffected.
//  6. All bounds 1 -> one tuple (0,0,0) with idx_last=3'b111, done pulse next cycle.

Source files
------------

// File: rtl/loop_nest_counter.sv
// Nested-loop index generator: NUM_DIMS chained wrap-around counters (dim 0 innermost)
// with clamped per-dim bounds, valid/ready tuple output and a done pulse per nest.

module loop_dim_ctr #(
    parameter int CW        = 4,
    parameter int MAX_COUNT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          zero,
    input  logic          inc,
    input  logic [CW-1:0] bound_in,
    output logic [CW-1:0] idx,
    output logic          last
);
    logic [CW-1:0] bound;
    logic [CW-1:0] bound_clamped;

    always_comb begin
        bound_clamped = bound_in;
        if (bound_in == '0)
            bound_clamped = CW'(1);
        else if (bound_in > CW'(MAX_COUNT))
            bound_clamped = CW'(MAX_COUNT);
    end

    // bound is 0 only before the first start, so last stays low until then
    assign last = (idx == bound - CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx   <= '0;
            bound <= '0;
        end else if (load) begin
            idx   <= '0;
            bound <= bound_clamped;
        end else if (zero) begin
            idx <= '0;
        end else if (inc) begin
            idx <= last ? '0 : idx + CW'(1);
        end
    end
endmodule

module loop_nest_counter #(
    parameter  int NUM_DIMS  = 3,
    parameter  int MAX_COUNT = 8,
    localparam int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clear,
    input  logic [NUM_DIMS*CW-1:0] bounds,
    output logic                   idx_valid,
    input  logic                   idx_ready,
    output logic [NUM_DIMS*CW-1:0] idx,
    output logic [NUM_DIMS-1:0]    idx_last,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state;
    logic [NUM_DIMS-1:0][CW-1:0] bnd;
    logic [NUM_DIMS-1:0][CW-1:0] idx_q;
    logic [NUM_DIMS:0]          carry;
    logic                       accept, adv, fin;

    assign bnd    = bounds;
    assign idx    = idx_q;
    assign accept = (state == IDLE) & start & ~clear;
    assign adv    = (state == RUN) & idx_valid & idx_ready;
    assign fin    = adv & (&idx_last);

    // dim d steps only when every inner dim is at its last value
    always_comb begin
        carry[0] = adv;
        for (int d = 0; d < NUM_DIMS; d++)
            carry[d+1] = carry[d] & idx_last[d];
    end

    for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
        loop_dim_ctr #(.CW(CW), .MAX_COUNT(MAX_COUNT)) u_dim (
            .clk      (clk),
            .rst      (rst),
            .load     (accept),
            .zero     (clear | fin),
            .inc      (carry[d]),
            .bound_in (bnd[d]),
            .idx      (idx_q[d]),
            .last     (idx_last[d])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state     <= RUN;
                        idx_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (fin) begin
                        state     <= DONE;
                        idx_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    idx_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_loop_nest_counter.sv
// Scoreboard bench for loop_nest_counter: expected tuples are queued by the stimulus,
// a negedge monitor pops and compares them on every handshake.

module tb_loop_nest_counter;
    localparam int ND = 3;
    localparam int MC = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst, start, clear, idx_ready, idx_valid, busy, done;
    logic [ND*CW-1:0]  bounds, idx;
    logic [ND-1:0]     idx_last;

    int n_chk  = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    int rdy_mode = 1;

    typedef struct packed {
        logic [ND*CW-1:0] i;
        logic [ND-1:0]    l;
    } tup_t;
    tup_t q[$];

    always #5 clk = ~clk;

    loop_nest_counter #(.NUM_DIMS(ND), .MAX_COUNT(MC)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .bounds(bounds),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx),
        .idx_last(idx_last), .busy(busy), .done(done)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_nest(int b2, int b1, int b0);
        tup_t t;
        for (int i2 = 0; i2 < b2; i2++)
            for (int i1 = 0; i1 < b1; i1++)
                for (int i0 = 0; i0 < b0; i0++) begin
                    t.i = {4'(i2), 4'(i1), 4'(i0)};
                    t.l = {i2 == b2 - 1, i1 == b1 - 1, i0 == b0 - 1};
                    q.push_back(t);
                end
    endtask

    // Start a nest, then wait (bounded) for done; optional start glitch while running
    task automatic run_nest(string nm, logic [ND*CW-1:0] raw, int exp_cyc, int glitch_at);
        int  k;
        logic seen;
        bounds = raw;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bounds = ~raw;
        seen   = 1'b0;
        for (k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({nm, " lat_valid"}, 32'(idx_valid), 32'd1);
                chk({nm, " lat_busy"}, 32'(busy), 32'd1);
                chk({nm, " lat_idx"}, 32'(idx), 32'd0);
            end
            if (glitch_at != 0 && k == glitch_at) begin
                start  = 1'b1;
                bounds = 12'h111;
            end else if (glitch_at != 0 && k == glitch_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({nm, " done_seen"}, 32'(seen), 32'd1);
        if (exp_cyc != 0) chk({nm, " cycles"}, 32'(k), 32'(exp_cyc));
        chk({nm, " done_busy"}, 32'(busy), 32'd0);
        chk({nm, " done_valid"}, 32'(idx_valid), 32'd0);
        chk({nm, " done_idx"}, 32'(idx), 32'd0);
        @(negedge clk);
        chk({nm, " done_width"}, 32'(done), 32'd0);
        chk({nm, " q_empty"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        idx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            idx_ready = (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic             hold;
        logic [ND*CW-1:0] held;
        tup_t             e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 32'(idx_valid), 32'd1);
                    chk("hold_idx", 32'(idx), 32'(held));
                end
                if (idx_valid && idx_ready && !clear) begin
                    hs_cnt++;
                    if (q.size() == 0) begin
                        chk("extra_tuple", 32'(idx), 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("idx", 32'(idx), 32'(e.i));
                        chk("idx_last", 32'(idx_last), 32'(e.l));
                    end
                end
                hold = idx_valid && !idx_ready && !clear;
                held = idx;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; clear = 1'b0; bounds = '0;
        #1;
        chk("rst_valid", 32'(idx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: bounds d2=2 d1=3 d0=2, ready always high
        push_nest(2, 3, 2);
        run_nest("t1", {4'd2, 4'd3, 4'd2}, 13, 0);

        // 2: same bounds, random back-pressure
        rdy_mode = 0;
        push_nest(2, 3, 2);
        run_nest("t2", {4'd2, 4'd3, 4'd2}, 0, 0);
        rdy_mode = 1;
        @(posedge clk); #1;

        // 3: clamping 0->1 and 9->8
        push_nest(1, 8, 1);
        run_nest("t3", {4'd0, 4'd9, 4'd1}, 9, 0);

        // 4: clear after 5th handshake
        push_nest(2, 3, 2);
        hs_cnt = 0;
        bounds = {4'd2, 4'd3, 4'd2};
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        for (int k = 0; k < 50 && hs_cnt < 5; k++) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("t4 hs_before_clear", 32'(hs_cnt), 32'd5);
        @(negedge clk);
        chk("t4 clr_valid", 32'(idx_valid), 32'd0);
        chk("t4 clr_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t4 no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("t4 remaining", 32'(q.size()), 32'd7);
        q.delete();
        push_nest(2, 3, 2);
        run_nest("t4r", {4'd2, 4'd3, 4'd2}, 13, 0);

        // 5: async reset mid-run, then start glitch while running
        push_nest(2, 3, 2);
        hs_cnt = 0;
        bounds = {4'd2, 4'd3, 4'd2};
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        for (int k = 0; k < 50 && hs_cnt < 3; k++) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t5 rst_valid", 32'(idx_valid), 32'd0);
        chk("t5 rst_busy", 32'(busy), 32'd0);
        chk("t5 rst_done", 32'(done), 32'd0);
        chk("t5 rst_idx", 32'(idx), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        push_nest(2, 3, 2);
        run_nest("t5g", {4'd2, 4'd3, 4'd2}, 13, 4);

        // 6: all bounds 1 -> single tuple
        push_nest(1, 1, 1);
        run_nest("t6", {4'd1, 4'd1, 4'd1}, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
